// File: rtl/spi_cpu_pkg.sv
// Shared definitions for the SPI fetch arbiter: state encoding and timeout defaults.
package spi_cpu_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC   = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC    = 2'd2;
  localparam logic [1:0] ST_RESPOND_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_ISSUE   = ST_ISSUE_ENC,
    ST_WAIT    = ST_WAIT_ENC,
    ST_RESPOND = ST_RESPOND_ENC
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_CNT_W          = 7;

endpackage

// File: rtl/spi_fetch_arbiter.sv
// Round-robin arbiter serialising instruction-fetch and data-load byte reads
// onto a single SPI byte reader, with a per-transaction timeout.
module spi_fetch_arbiter
  import spi_cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic        req1,
  input  logic [15:0] addr1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic        spi_start,
  output logic [15:0] spi_addr,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_data
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q;
  logic             grant_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      spi_addr_q;
  logic [7:0]       rdata_q;
  logic             err_q;
  logic             spi_start_q;
  logic             done0_q;
  logic             done1_q;
  logic             winner_d;

  // A lone requester always wins; a tie goes to whoever was not served last.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    if (r0) begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  assign winner_d = pick_winner(req0, req1, last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      spi_addr_q  <= 16'h0000;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      spi_start_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      // Pulses self-clear every edge so a stalled enable never stretches them.
      spi_start_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      if (ena) begin
        case (state_q)
          ST_IDLE: begin
            if (req0 || req1) begin
              grant_q    <= winner_d;
              spi_addr_q <= winner_d ? addr1 : addr0;
              state_q    <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (!spi_busy) begin
              spi_start_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (spi_done) begin
              rdata_q <= spi_data;
              err_q   <= 1'b0;
              done0_q <= ~grant_q;
              done1_q <= grant_q;
              state_q <= ST_RESPOND;
            end else if (cnt_q == TimeoutVal) begin
              rdata_q <= 8'hFF;
              err_q   <= 1'b1;
              done0_q <= ~grant_q;
              done1_q <= grant_q;
              state_q <= ST_RESPOND;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RESPOND: begin
            last_q  <= grant_q;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign spi_start = spi_start_q;
  assign spi_addr  = spi_addr_q;

endmodule

// File: tb/tb_spi_fetch_arbiter.sv
// Self-checking bench for spi_fetch_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration/timeout model.
module tb_spi_fetch_arbiter;

  localparam int Timeout = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        req0;
  logic [15:0] addr0;
  logic        req1;
  logic [15:0] addr1;
  logic        done0;
  logic        done1;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic        spi_start;
  logic [15:0] spi_addr;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_data;

  int          assertCount = 0;
  int          failCount = 0;
  int          respLatency = -1;
  logic [7:0]  respData = 8'h00;
  bit          strayDone = 1'b0;
  logic        benchLast = 1'b1;

  always #5 clk = ~clk;

  spi_fetch_arbiter #(
    .TIMEOUT_CYCLES(Timeout),
    .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .req0(req0),
    .addr0(addr0),
    .req1(req1),
    .addr1(addr1),
    .done0(done0),
    .done1(done1),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .spi_start(spi_start),
    .spi_addr(spi_addr),
    .spi_busy(spi_busy),
    .spi_done(spi_done),
    .spi_data(spi_data)
  );

  // SPI byte reader stand-in: answers respLatency cycles after each start (never if <= 0).
  initial begin : spiResponder
    bit pending;
    int countdown;
    pending   = 1'b0;
    countdown = 0;
    spi_done  = 1'b0;
    spi_data  = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = strayDone;
      if (spi_start) begin
        pending   = (respLatency > 0);
        countdown = respLatency;
      end else if (pending) begin
        countdown--;
        if (countdown == 0) begin
          spi_done = 1'b1;
          spi_data = respData;
          pending  = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference arbitration: lone requester wins, tie goes to the one not served last.
  function automatic logic predictWinner(input logic r0, input logic r1);
    if (r0 && r1) return !benchLast;
    return !r0;
  endfunction

  task automatic applyStimulus(input logic r0, input logic [15:0] a0, input logic r1, input logic [15:0] a1);
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
  endtask

  task automatic runTransaction(input string tag, input logic expWin, input logic [15:0] expAddr,
                                input int expStartDelay, input int latency, input int enaDropAt,
                                input bit dropAfterStart, input bit holdReq);
    int          cycles;
    int          expLat;
    bit          expErr;
    logic [7:0]  expData;
    logic [15:0] waitAddr;
    respLatency = latency;
    expErr  = (latency <= 0) || (latency > Timeout);
    expData = expErr ? 8'hFF : respData;
    expLat  = (expErr ? Timeout : latency) + 1 + ((enaDropAt >= 0) ? 5 : 0);

    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!spi_start && cycles < 40);
    checkOutput({tag, "/startSeen"}, spi_start, 1'b1);
    if (!spi_start) return;
    if (expStartDelay >= 0) checkOutput({tag, "/startDelay"}, cycles, expStartDelay);
    checkOutput({tag, "/spiAddr"}, spi_addr, expAddr);

    if (dropAfterStart) begin
      req0  = 1'b0;
      req1  = 1'b0;
      addr0 = ~expAddr;
      addr1 = ~expAddr;
    end

    cycles   = 0;
    waitAddr = spi_addr;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == enaDropAt) ena = 1'b0;
      if (enaDropAt >= 0 && cycles == enaDropAt + 5) ena = 1'b1;
      if (!(done0 || done1)) waitAddr = spi_addr;
    end while (!(done0 || done1) && cycles < 200);
    ena = 1'b1;

    checkOutput({tag, "/doneLatency"}, cycles, expLat);
    checkOutput({tag, "/done0"}, done0, !expWin);
    checkOutput({tag, "/done1"}, done1, expWin);
    checkOutput({tag, "/rdata"}, rdata, expData);
    checkOutput({tag, "/err"}, err, expErr);
    checkOutput({tag, "/addrHeld"}, waitAddr, expAddr);
    benchLast = expWin;
    if (!holdReq) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end

    @(negedge clk);
    checkOutput({tag, "/pulseWidth"}, {done0, done1}, 2'b00);
    checkOutput({tag, "/rdataHold"}, rdata, expData);
    checkOutput({tag, "/errHold"}, err, expErr);
  endtask

  initial begin : mainSequence
    int   cycles;
    bit   sawDone;
    logic w;

    // Reset with the clock enable low must still clear everything.
    rst      = 1'b1;
    ena      = 1'b0;
    spi_busy = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("reset/busy", busy, 1'b0);
    checkOutput("reset/start", spi_start, 1'b0);
    checkOutput("reset/done", {done0, done1}, 2'b00);
    checkOutput("reset/err", err, 1'b0);
    checkOutput("reset/rdata", rdata, 8'h00);
    checkOutput("reset/spiAddr", spi_addr, 16'h0000);
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    $display("[TB] single requester 0");
    respData = 8'hA5;
    applyStimulus(1'b1, 16'h0003, 1'b0, 16'h0000);
    runTransaction("single0", predictWinner(1'b1, 1'b0), 16'h0003, 2, 20, -1, 1'b0, 1'b0);

    $display("[TB] stray spi_done while idle");
    @(negedge clk);
    #2 strayDone = 1'b1;
    @(negedge clk);
    #2 strayDone = 1'b0;
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sawDone |= (done0 | done1);
    end
    checkOutput("stray/done", sawDone, 1'b0);
    checkOutput("stray/busy", busy, 1'b0);
    checkOutput("stray/rdata", rdata, 8'hA5);

    $display("[TB] round robin with both requests held");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    benchLast = 1'b1;
    applyStimulus(1'b1, 16'h0001, 1'b1, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      w = predictWinner(1'b1, 1'b1);
      respData = 8'($urandom);
      runTransaction($sformatf("rr%0d", i), w, w ? 16'h0100 : 16'h0001, 2, 5 + i, -1, 1'b0, i < 3);
    end

    $display("[TB] timeout");
    respData = 8'($urandom);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'hBEEF);
    runTransaction("timeout", predictWinner(1'b0, 1'b1), 16'hBEEF, 2, -1, -1, 1'b0, 1'b0);

    $display("[TB] spi_busy stalls issue");
    spi_busy = 1'b1;
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0000);
    sawDone = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawDone |= spi_start;
    end
    checkOutput("busyHold/start", sawDone, 1'b0);
    checkOutput("busyHold/busy", busy, 1'b1);
    spi_busy = 1'b0;
    respData = 8'($urandom);
    runTransaction("busyRelease", predictWinner(1'b1, 1'b0), 16'h1234, 1, 7, -1, 1'b0, 1'b0);

    $display("[TB] enable freeze during wait");
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h00F0);
    runTransaction("enaFreeze", predictWinner(1'b0, 1'b1), 16'h00F0, 2, -1, 10, 1'b0, 1'b0);

    $display("[TB] request and address dropped after grant");
    respData = 8'($urandom);
    applyStimulus(1'b1, 16'h4242, 1'b1, 16'h2424);
    w = predictWinner(1'b1, 1'b1);
    runTransaction("dropReq", w, w ? 16'h2424 : 16'h4242, 2, 12, -1, 1'b1, 1'b0);

    $display("[TB] reset during wait");
    respLatency = 10;
    respData    = 8'h3C;
    applyStimulus(1'b1, 16'h0777, 1'b0, 16'h0000);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!spi_start && cycles < 40);
    checkOutput("rstWait/startSeen", spi_start, 1'b1);
    repeat (3) @(negedge clk);
    rst  = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    benchLast = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sawDone |= (done0 | done1);
    end
    checkOutput("rstWait/noDone", sawDone, 1'b0);
    checkOutput("rstWait/busy", busy, 1'b0);
    checkOutput("rstWait/rdata", rdata, 8'h00);
    checkOutput("rstWait/err", err, 1'b0);
    checkOutput("rstWait/spiAddr", spi_addr, 16'h0000);
    respData = 8'($urandom);
    applyStimulus(1'b1, 16'h0888, 1'b1, 16'h0999);
    runTransaction("postReset", predictWinner(1'b1, 1'b1), 16'h0888, 2, 9, -1, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 12; i++) begin
      logic        r0;
      logic        r1;
      logic [15:0] a0;
      logic [15:0] a1;
      int          lat;
      case ($urandom_range(0, 2))
        0:       {r0, r1} = 2'b10;
        1:       {r0, r1} = 2'b01;
        default: {r0, r1} = 2'b11;
      endcase
      a0       = 16'($urandom);
      a1       = 16'($urandom);
      respData = 8'($urandom);
      if (i == 3)      lat = Timeout;
      else if (i == 7) lat = Timeout + 1;
      else             lat = $urandom_range(1, 40);
      w = predictWinner(r0, r1);
      applyStimulus(r0, a0, r1, a1);
      runTransaction($sformatf("rand%0d", i), w, w ? a1 : a0, 2, lat, -1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
